// File: rtl/ex_cs_add_norm64_pkg.sv
// Shared widths and constants for the 64-bit add / CLZ / normalize slice.
package ex_cs_add_norm64_pkg;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam logic [CW-1:0] CLZ_ZERO = 8'h80;

    typedef struct packed {
        logic          zero;
        logic [1:0]    cnt;
    } nibClz_t;

    typedef struct packed {
        logic          zero;
        logic [3:0]    cnt;
    } grpClz_t;

    // Leading-zero count of one nibble, with an all-zero flag.
    function automatic nibClz_t clzNib(input logic [3:0] n);
        nibClz_t r;
        r.zero = (n == 4'd0);
        if (n[3])      r.cnt = 2'd0;
        else if (n[2]) r.cnt = 2'd1;
        else if (n[1]) r.cnt = 2'd2;
        else           r.cnt = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/ex_cs_clz64.sv
// Tree-structured 64-bit leading-zero counter: nibbles -> 16-bit groups -> 64-bit.
module ex_cs_clz64
    import ex_cs_add_norm64_pkg::*;
(
    input  logic [DW-1:0] x,
    output logic [CW-1:0] cnt
);

    function automatic grpClz_t clzGrp(input logic [15:0] g);
        nibClz_t n3, n2, n1, n0;
        grpClz_t r;
        n3 = clzNib(g[15:12]);
        n2 = clzNib(g[11:8]);
        n1 = clzNib(g[7:4]);
        n0 = clzNib(g[3:0]);
        r = '{zero: 1'b1, cnt: 4'd0};
        if (!n3.zero)      r = '{zero: 1'b0, cnt: {2'd0, n3.cnt}};
        else if (!n2.zero) r = '{zero: 1'b0, cnt: {2'd1, n2.cnt}};
        else if (!n1.zero) r = '{zero: 1'b0, cnt: {2'd2, n1.cnt}};
        else if (!n0.zero) r = '{zero: 1'b0, cnt: {2'd3, n0.cnt}};
        return r;
    endfunction

    grpClz_t g3, g2, g1, g0;

    assign g3 = clzGrp(x[63:48]);
    assign g2 = clzGrp(x[47:32]);
    assign g1 = clzGrp(x[31:16]);
    assign g0 = clzGrp(x[15:0]);

    // The first non-empty group from the top supplies the upper two count bits.
    always_comb begin
        cnt = CLZ_ZERO;
        if (!g3.zero)      cnt = {2'b00, 2'd0, g3.cnt};
        else if (!g2.zero) cnt = {2'b00, 2'd1, g2.cnt};
        else if (!g1.zero) cnt = {2'b00, 2'd2, g1.cnt};
        else if (!g0.zero) cnt = {2'b00, 2'd3, g0.cnt};
    end

endmodule

// File: rtl/ex_cs_add_norm64.sv
// Registered 64-bit add, leading-zero count and left-normalize in one pipeline stage.
module ex_cs_add_norm64
    import ex_cs_add_norm64_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic          cin,
    input  logic          use_ext,
    input  logic [CW-1:0] ext_shl,
    output logic          out_valid,
    output logic [DW:0]   sum,
    output logic [CW-1:0] clz,
    output logic [DW-1:0] norm
);

    logic [DW:0]   sumNext;
    logic [DW-1:0] x;
    logic [CW-1:0] clzNext;
    logic [CW-1:0] shiftAmt;
    logic [DW-1:0] s0, s1, s2, s3, s4, s5, s6;
    logic [DW-1:0] normNext;

    assign sumNext = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, cin};
    assign x       = sumNext[DW-1:0];

    ex_cs_clz64 clzUnit (
        .x   (x),
        .cnt (clzNext)
    );

    assign shiftAmt = use_ext ? ext_shl : clzNext;

    // Log shifter; the 64 stage and the kill bit both clear the result.
    assign s0 = shiftAmt[0] ? {x[62:0],  1'b0}  : x;
    assign s1 = shiftAmt[1] ? {s0[61:0], 2'b0}  : s0;
    assign s2 = shiftAmt[2] ? {s1[59:0], 4'b0}  : s1;
    assign s3 = shiftAmt[3] ? {s2[55:0], 8'b0}  : s2;
    assign s4 = shiftAmt[4] ? {s3[47:0], 16'b0} : s3;
    assign s5 = shiftAmt[5] ? {s4[31:0], 32'b0} : s4;
    assign s6 = shiftAmt[6] ? '0 : s5;
    assign normNext = shiftAmt[7] ? '0 : s6;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            clz       <= '0;
            norm      <= '0;
        end else if (!hold) begin
            out_valid <= in_valid;
            sum       <= sumNext;
            clz       <= clzNext;
            norm      <= normNext;
        end
    end

endmodule

// File: tb/tb_ex_cs_add_norm64.sv
// Self-checking bench for ex_cs_add_norm64: directed corner cases plus randomized traffic.
module tb_ex_cs_add_norm64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        inValid = 1'b0;
    logic [63:0] opA = '0;
    logic [63:0] opB = '0;
    logic        cin = 1'b0;
    logic        useExt = 1'b0;
    logic [7:0]  extShl = '0;
    logic        outValid;
    logic [64:0] sum;
    logic [7:0]  clz;
    logic [63:0] norm;

    logic        expValid = 1'b0;
    logic [64:0] expSum = '0;
    logic [7:0]  expClz = '0;
    logic [63:0] expNorm = '0;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;

    ex_cs_add_norm64 dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .in_valid  (inValid),
        .op_a      (opA),
        .op_b      (opB),
        .cin       (cin),
        .use_ext   (useExt),
        .ext_shl   (extShl),
        .out_valid (outValid),
        .sum       (sum),
        .clz       (clz),
        .norm      (norm)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] refClz(input logic [63:0] v);
        if (v == 64'd0) return 8'h80;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) return 8'(63 - i);
        end
        return 8'h80;
    endfunction

    function automatic logic [63:0] refShift(input logic [63:0] v, input logic [7:0] amt);
        int n;
        n = int'(amt[6:0]);
        if (amt[7] || n >= 64) return 64'd0;
        return v << n;
    endfunction

    task automatic checkField(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".valid"}, {64'd0, outValid}, {64'd0, expValid});
        checkField({tag, ".sum"},   sum,               expSum);
        checkField({tag, ".clz"},   {57'd0, clz},      {57'd0, expClz});
        checkField({tag, ".norm"},  {1'b0, norm},      {1'b0, expNorm});
    endtask

    // Drive one cycle, advance the reference model, then sample after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic hld, input logic vld,
                                 input logic [63:0] a, input logic [63:0] b, input logic c,
                                 input logic ue, input logic [7:0] es);
        logic [64:0] s;
        logic [7:0]  cz;
        reset = rst; hold = hld; inValid = vld;
        opA = a; opB = b; cin = c; useExt = ue; extShl = es;
        s  = 65'(a) + 65'(b) + 65'(c);
        cz = refClz(s[63:0]);
        if (rst) begin
            expValid = 1'b0; expSum = '0; expClz = '0; expNorm = '0;
        end else if (!hld) begin
            expValid = vld;
            expSum   = s;
            expClz   = cz;
            expNorm  = refShift(s[63:0], ue ? es : cz);
        end
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [63:0] a, b;
        logic [7:0]  es;
        #2;
        applyStimulus("reset0", 1, 0, 1, 64'h5, 64'h7, 1, 0, 8'd0);
        applyStimulus("reset1", 1, 0, 0, 64'h0, 64'h0, 0, 0, 8'd0);

        applyStimulus("allOnesPlusCin", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 8'd0);
        applyStimulus("one",            0, 0, 1, 64'h1, 64'h0, 0, 0, 8'd0);
        applyStimulus("carryChain",     0, 0, 1, 64'h1_0000, 64'hFFFF, 1, 0, 8'd0);
        applyStimulus("extShift4",      0, 0, 1, 64'h1, 64'h0, 0, 1, 8'd4);
        applyStimulus("extKill",        0, 0, 1, 64'h1, 64'h0, 0, 1, 8'h80);
        applyStimulus("extShift64",     0, 0, 0, 64'h1, 64'h0, 0, 1, 8'd64);
        applyStimulus("msbPlusMsb",     0, 0, 1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 8'd0);
        applyStimulus("topBit",         0, 0, 1, 64'h8000_0000_0000_0000, 64'h0, 0, 0, 8'd0);

        applyStimulus("loadBeforeHold", 0, 0, 1, 64'h0123_4567, 64'h89AB, 0, 0, 8'd0);
        applyStimulus("hold0",          0, 1, 0, 64'hDEAD_BEEF, 64'h1, 1, 1, 8'd3);
        applyStimulus("hold1",          0, 1, 1, 64'h0, 64'h0, 0, 0, 8'd0);
        applyStimulus("hold2",          0, 1, 0, 64'hFFFF, 64'hFFFF, 1, 1, 8'h85);
        applyStimulus("resetOverHold",  1, 1, 1, 64'h1234, 64'h1, 0, 0, 8'd0);

        for (int i = 0; i < 300; i++) begin
            a  = {$urandom, $urandom} >> $urandom_range(63, 0);
            b  = ($urandom_range(3, 0) == 0) ? {$urandom, $urandom} : 64'd0;
            es = 8'($urandom_range(255, 0));
            applyStimulus("random", ($urandom_range(40, 0) == 0), ($urandom_range(7, 0) == 0),
                          1'($urandom), a, b, 1'($urandom), 1'($urandom), es);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
